// File: rtl/algo_pque_req_arb_pkg.sv
// Shared sizing defaults and pop-tag types for the pque request arbiter.
// No logic; referenced by the arbiter top and the bench.
// Response latency (accept to rsp_vld) is POP_DELAY+2 cycles.
package algo_pque_req_arb_pkg;

    localparam int NUMREQ_DEF    = 4;
    localparam int BITREQ_DEF    = 2;
    localparam int BITQPRT_DEF   = 6;
    localparam int BITQPTR_DEF   = 13;
    localparam int BITQCNT_DEF   = BITQPTR_DEF + 1;
    localparam int POP_DELAY_DEF = 3;
    localparam int RSP_LATENCY   = POP_DELAY_DEF + 2;

    typedef logic [BITREQ_DEF-1:0] reqId_t;

    typedef struct packed {
        logic   vld;
        reqId_t reqId;
    } tag_t;

endpackage

// File: rtl/algo_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Grant is combinational; the pointer updates on the clock after a grant.
// No grant while en is low; the pointer then holds.
module algo_rr_arb #(
    parameter int NUMREQ = 4,
    parameter int BITREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUMREQ-1:0] req,
    output logic [NUMREQ-1:0] gnt,
    output logic              gntVld,
    output logic [BITREQ-1:0] gntIdx
);

    logic [BITREQ-1:0] rrPtr;
    logic [BITREQ-1:0] winIdx;
    logic [BITREQ-1:0] idx;
    logic              found;

    always_comb begin
        found  = 1'b0;
        winIdx = '0;
        idx    = '0;
        for (int i = 0; i < NUMREQ; i++) begin
            idx = BITREQ'((int'(rrPtr) + i) % NUMREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winIdx = idx;
            end
        end
    end

    assign gntVld = en & found;
    assign gntIdx = winIdx;

    always_comb begin
        gnt = '0;
        if (gntVld) begin
            gnt[winIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtr <= '0;
        end else if (gntVld) begin
            rrPtr <= (winIdx == BITREQ'(NUMREQ - 1)) ? '0 : winIdx + BITREQ'(1);
        end
    end

endmodule

// File: rtl/algo_pque_req_arb.sv
// Shares the pque push/pop ports among NUMREQ requesters and routes pop responses back.
// Command one cycle after accept; response POP_DELAY+2 cycles after accept.
// Grants held off while ready is low; in-flight pops still drain and respond.
module algo_pque_req_arb
    import algo_pque_req_arb_pkg::*;
#(
    parameter int NUMREQ    = NUMREQ_DEF,
    parameter int BITREQ    = BITREQ_DEF,
    parameter int BITQPRT   = BITQPRT_DEF,
    parameter int BITQPTR   = BITQPTR_DEF,
    parameter int BITQCNT   = BITQCNT_DEF,
    parameter int POP_DELAY = POP_DELAY_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ready,
    input  logic [NUMREQ-1:0]         rq_push,
    input  logic [NUMREQ*BITQPRT-1:0] rq_pu_prt,
    input  logic [NUMREQ*BITQPTR-1:0] rq_pu_ptr,
    output logic [NUMREQ-1:0]         rq_pu_gnt,
    input  logic [NUMREQ-1:0]         rq_pop,
    input  logic [NUMREQ-1:0]         rq_po_ndq,
    input  logic [NUMREQ*BITQPRT-1:0] rq_po_prt,
    output logic [NUMREQ-1:0]         rq_po_gnt,
    output logic                      push,
    output logic [BITQPRT-1:0]        pu_prt,
    output logic [BITQPTR-1:0]        pu_ptr,
    output logic                      pop,
    output logic                      po_ndq,
    output logic [BITQPRT-1:0]        po_prt,
    input  logic                      po_cvld,
    input  logic [BITQCNT-1:0]        po_cnt,
    input  logic                      po_pvld,
    input  logic [BITQPTR-1:0]        po_ptr,
    output logic [NUMREQ-1:0]         rsp_vld,
    output logic                      rsp_pvld,
    output logic [BITQCNT-1:0]        rsp_cnt,
    output logic [BITQPTR-1:0]        rsp_ptr,
    output logic                      err
);

    // Grants are also suppressed while reset is asserted.
    logic              arbEn;
    logic              puAcc;
    logic              poAcc;
    logic [BITREQ-1:0] puIdx;
    logic [BITREQ-1:0] poIdx;

    assign arbEn = ready & rst;

    algo_rr_arb #(
        .NUMREQ (NUMREQ),
        .BITREQ (BITREQ)
    ) u_pushArb (
        .clk    (clk),
        .rst    (rst),
        .en     (arbEn),
        .req    (rq_push),
        .gnt    (rq_pu_gnt),
        .gntVld (puAcc),
        .gntIdx (puIdx)
    );

    algo_rr_arb #(
        .NUMREQ (NUMREQ),
        .BITREQ (BITREQ)
    ) u_popArb (
        .clk    (clk),
        .rst    (rst),
        .en     (arbEn),
        .req    (rq_pop),
        .gnt    (rq_po_gnt),
        .gntVld (poAcc),
        .gntIdx (poIdx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push   <= 1'b0;
            pu_prt <= '0;
            pu_ptr <= '0;
            pop    <= 1'b0;
            po_ndq <= 1'b0;
            po_prt <= '0;
        end else begin
            push <= puAcc;
            pop  <= poAcc;
            if (puAcc) begin
                pu_prt <= rq_pu_prt[puIdx*BITQPRT +: BITQPRT];
                pu_ptr <= rq_pu_ptr[puIdx*BITQPTR +: BITQPTR];
            end
            if (poAcc) begin
                po_ndq <= rq_po_ndq[poIdx];
                po_prt <= rq_po_prt[poIdx*BITQPRT +: BITQPRT];
            end
        end
    end

    // Tag stage k is visible k+1 cycles after accept, so the tail lines up with po_cvld.
    tag_t tagPipe [POP_DELAY+1];
    tag_t tail;

    assign tail = tagPipe[POP_DELAY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= POP_DELAY; k++) begin
                tagPipe[k] <= '0;
            end
        end else begin
            tagPipe[0] <= '{vld: poAcc, reqId: poIdx};
            for (int k = 1; k <= POP_DELAY; k++) begin
                tagPipe[k] <= tagPipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld  <= '0;
            rsp_pvld <= 1'b0;
            rsp_cnt  <= '0;
            rsp_ptr  <= '0;
            err      <= 1'b0;
        end else begin
            err <= err | (tail.vld ^ po_cvld);
            if (tail.vld && po_cvld) begin
                rsp_vld  <= NUMREQ'(1) << tail.reqId;
                rsp_pvld <= po_pvld;
                rsp_cnt  <= po_cnt;
                rsp_ptr  <= po_ptr;
            end else begin
                rsp_vld <= '0;
            end
        end
    end

endmodule

// File: doc/algo_pque_req_arb.md
Name: algo_pque_req_arb

Overview:
- Front-end arbiter for the single push port and single pop port of the priority-queue algo (NUMPUPT=NUMPOPT=1 configuration).
- Shares both ports among NUMREQ requesters using independent round-robin arbiters for push and pop.
- Registers the winning command toward the pque.
- Tags every issued pop and steers the fixed-latency pop response (count, pointer) back to the originating requester; flags protocol errors.

Parameters:
NUMREQ, 4, number of requesters
BITREQ, 2, log2(NUMREQ)
BITQPRT, 6, queue/priority index width
BITQPTR, 13, pointer width
BITQCNT, 14, queue count width (BITQPTR+1)
POP_DELAY, 3, pque cycles from pop sampled to po_cvld/po_pvld asserted (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ready  in  1  pque ready; no grants while low
rq_push  in  NUMREQ  per-requester push request
rq_pu_prt  in  NUMREQ*BITQPRT  push queue index, requester r at slice r
rq_pu_ptr  in  NUMREQ*BITQPTR  push pointer
rq_pu_gnt  out  NUMREQ  one-hot push accept (combinational)
rq_pop  in  NUMREQ  per-requester pop request
rq_po_ndq  in  NUMREQ  pop is peek (no dequeue)
rq_po_prt  in  NUMREQ*BITQPRT  pop queue index
rq_po_gnt  out  NUMREQ  one-hot pop accept (combinational)
push  out  1  to pque, registered
pu_prt  out  BITQPRT  to pque
pu_ptr  out  BITQPTR  to pque
pop  out  1  to pque, registered
po_ndq  out  1  to pque
po_prt  out  BITQPRT  to pque
po_cvld  in  1  pque pop count valid
po_cnt  in  BITQCNT  pque pop count
po_pvld  in  1  pque pointer valid (queue non-empty)
po_ptr  in  BITQPTR  pque popped pointer
rsp_vld  out  NUMREQ  one-hot pop response strobe, registered
rsp_pvld  out  1  registered po_pvld, broadcast
rsp_cnt  out  BITQCNT  registered po_cnt, broadcast
rsp_ptr  out  BITQPTR  registered po_ptr, broadcast
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): every output 0 (push, pop, pu_*, po_*, rsp_*, err); both round-robin pointers 0; tag pipe cleared. Grants are 0 during reset.
- Arbitration:
  - Push and pop arbitrate independently in the same cycle.
  - Winner is the first requesting index at or after its RR pointer, wrapping modulo NUMREQ.
  - Grant asserted only when ready=1 and a request exists.
  - On a grant to r, the pointer becomes (r+1) mod NUMREQ; with no grant the pointer holds.
  - Accept = rq_x & rq_x_gnt. Requester holds request and fields until granted.
- Command stage:
  - An accept in cycle T drives push/pop plus fields from the winning slice on the pque port in T+1.
  - With no accept, push/pop=0 and fields hold their previous values.
- Tag pipe:
  - Shift register of depth POP_DELAY+1, entries {vld, req_id}.
  - Entry loaded at accept (cycle T); pque returns po_cvld at T+1+POP_DELAY, when the entry reaches the pipe tail.
  - Response registered: rsp_vld[req_id]=1 at T+2+POP_DELAY, with rsp_cnt/rsp_ptr/rsp_pvld captured from the pque outputs.
  - rsp fields hold when rsp_vld=0.
- Throughput: one push and one pop per cycle sustained; back-to-back pops to the same queue are passed unchanged (pque resolves the hazard).
- ready deasserting mid-stream: no new grants; in-flight tags still drain and responses are still delivered.
- Errors:
  - po_cvld=1 with the tail entry invalid, or tail entry valid with po_cvld=0 → err=1.
  - err stays 1 until reset.
  - A mismatched tail entry is discarded with no rsp_vld.
- Reset mid-operation: in-flight pops are dropped with no response; arbitration restarts at requester 0.

Decomposition:
- Shared package: requester-id type, tag struct {vld, req_id}, POP_DELAY default. Response latency constant = POP_DELAY+2 relative to accept, for the bench.
- One sub-module, algo_rr_arb (NUMREQ request vector → one-hot grant plus pointer update, enable input), instantiated twice (push, pop).

Test Plan:
- Reset release, all four rq_pop=1, ready=1 → pop grants one-hot in order r0,r1,r2,r3,r0; pop=1 every cycle from cycle 1; pointer wraps 3→0.
- r2 pop accepted at T=10 with prt=5; pque returns po_cvld=1, po_cnt=7, po_pvld=1, po_ptr=0x123 at T=14 → rsp_vld=4'b0100, rsp_cnt=7, rsp_ptr=0x123 at T=15, and only then.
- Simultaneous rq_push=4'b1010 and rq_pop=4'b0101 → same-cycle grants push→r1, pop→r0; next cycle push→r3, pop→r2; push and pop both 1 on the pque port.
- ready=0 for 5 cycles with 2 pops in flight → no grants and no new push/pop; both rsp_vld strobes still appear at their scheduled cycles.
- Spurious po_cvld=1 with the tag pipe empty → err=1 next cycle, no rsp_vld, err held until rst=0.
- Assert rst=0 with 3 pops in flight, then release → all outputs 0 immediately; no rsp_vld after release; first grant goes to r0.
